// File: rtl/q15_pwm_dac.sv
// Q1.15 sample buffer driving a free-running PWM DAC; each period loads one buffered sample as its duty.
// Define Q15_PWM_DAC_ROUND_EN for round-to-nearest sample conversion (default build truncates).
module q15_pwm_dac #(
    parameter int unsigned PWM_BITS   = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                in_valid,
    input  logic [15:0]         in_data,
    output logic                in_ready,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                underrun
);

    localparam int unsigned         AW       = $clog2(FIFO_DEPTH);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] MIDSCALE = PWM_BITS'(1) << (PWM_BITS - 1);
    localparam logic [AW:0]         PTR_ONE  = (AW + 1)'(1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                underrun_q, underrun_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];

    logic [15:0]         sample_q15;
    logic [PWM_BITS-1:0] code;
    logic                unused_lsbs;
    logic                empty, full, wrap, push, pop;

`ifdef Q15_PWM_DAC_ROUND_EN
    localparam logic [16:0] RND_INC = 17'(1) << (15 - PWM_BITS);
    logic [16:0] rnd_sum;

    assign rnd_sum = {in_data[15], in_data} + RND_INC;
    // A positive increment can only overflow upward: bit 16 clear with bit 15 set means above +32767.
    assign sample_q15 = (!rnd_sum[16] && rnd_sum[15]) ? 16'h7FFF : rnd_sum[15:0];
`else
    assign sample_q15 = in_data;
`endif

    // Flipping the sign bit turns two's complement into offset binary.
    assign code        = sample_q15[15 -: PWM_BITS] ^ MIDSCALE;
    assign unused_lsbs = ^sample_q15[15 - PWM_BITS:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wrap  = clk_en && (cnt_q == CNT_MAX);
    assign push  = clk_en && in_valid && !full;
    assign pop   = wrap && !empty;

    always_comb begin
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        pwm_d      = pwm_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        underrun_d = wrap && empty;

        if (clk_en) begin
            cnt_d = cnt_q + CNT_ONE;
            pwm_d = (cnt_q < duty_q);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            duty_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            duty_q     <= MIDSCALE;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= code;
        end
    end

    assign in_ready = !full;
    assign pwm_out  = pwm_q;
    assign duty     = duty_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_q15_pwm_dac.sv
// Directed bench for q15_pwm_dac at PWM_BITS=12, FIFO_DEPTH=4; all windows align to 4096-tick periods.
// Define Q15_PWM_DAC_ROUND_EN here too when building the rounding variant.
module tb_q15_pwm_dac;

    localparam int PWM_BITS   = 12;
    localparam int FIFO_DEPTH = 4;

`ifdef Q15_PWM_DAC_ROUND_EN
    localparam logic [11:0] CODE_0008 = 12'd2049;
`else
    localparam logic [11:0] CODE_0008 = 12'd2048;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        pwm_out;
    logic [11:0] duty;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;
    int ur_cnt = 0;

    q15_pwm_dac #(
        .PWM_BITS  (PWM_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .pwm_out (pwm_out),
        .duty    (duty),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // One clk cycle; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (pwm_out === 1'b1) hi_cnt++;
        if (underrun === 1'b1) ur_cnt++;
    endtask

    task automatic run(input int n, input bit half);
        for (int i = 0; i < n; i++) begin
            if (half) begin
                clk_en = 1'b1;
                step();
                clk_en = 1'b0;
                step();
                clk_en = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        checks++; if (duty !== 12'd2048) begin errors++; $display("FAIL reset_duty got %0d want 2048", duty); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_idle();
        hi_cnt = 0; ur_cnt = 0;
        run(4096, 1'b0);
        checks++; if (hi_cnt != 2048) begin errors++; $display("FAIL idle_high got %0d want 2048", hi_cnt); end
        checks++; if (ur_cnt != 1) begin errors++; $display("FAIL idle_underrun_count got %0d want 1", ur_cnt); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_underrun_at_wrap got %b want 1", underrun); end
        checks++; if (duty !== 12'd2048) begin errors++; $display("FAIL idle_duty got %0d want 2048", duty); end
    endtask

    task automatic test_duty_sequence();
        int exp_hi[3]   = '{0, 4095, 2048};
        int exp_duty[3] = '{4095, 2048, 2048};
        int exp_ur[3]   = '{0, 0, 1};
        hi_cnt = 0; ur_cnt = 0;
        in_valid = 1'b1;
        in_data = 16'h8000; step();
        in_data = 16'h7FFF; step();
        in_data = 16'h0000; step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL seq_ready got %b want 1", in_ready); end
        run(4093, 1'b0);
        checks++; if (hi_cnt != 2048) begin errors++; $display("FAIL seq_high_p0 got %0d want 2048", hi_cnt); end
        checks++; if (ur_cnt != 0) begin errors++; $display("FAIL seq_underrun_p0 got %0d want 0", ur_cnt); end
        checks++; if (duty !== 12'd0) begin errors++; $display("FAIL seq_duty_p0 got %0d want 0", duty); end
        for (int p = 0; p < 3; p++) begin
            hi_cnt = 0; ur_cnt = 0;
            run(4096, 1'b0);
            checks++; if (hi_cnt != exp_hi[p]) begin errors++; $display("FAIL seq_high_p%0d got %0d want %0d", p + 1, hi_cnt, exp_hi[p]); end
            checks++; if (ur_cnt != exp_ur[p]) begin errors++; $display("FAIL seq_underrun_p%0d got %0d want %0d", p + 1, ur_cnt, exp_ur[p]); end
            checks++; if (duty !== 12'(exp_duty[p])) begin errors++; $display("FAIL seq_duty_p%0d got %0d want %0d", p + 1, duty, exp_duty[p]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] samples[5] = '{16'h0008, 16'h1000, 16'h2000, 16'h3000, 16'h4000};
        int exp_duty[3] = '{2304, 2560, 2816};
        hi_cnt = 0; ur_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = samples[i];
            step();
            if (i == 2) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after3 got %b want 1", in_ready); end
            end
            if (i == 3) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after4 got %b want 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        run(4090, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_prewrap got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_postwrap got %b want 1", in_ready); end
        checks++; if (duty !== CODE_0008) begin errors++; $display("FAIL b2b_duty_0008 got %0d want %0d", duty, CODE_0008); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun got %b want 0", underrun); end
        for (int p = 0; p < 3; p++) begin
            run(4096, 1'b0);
            checks++; if (duty !== 12'(exp_duty[p])) begin errors++; $display("FAIL b2b_duty_p%0d got %0d want %0d", p + 1, duty, exp_duty[p]); end
        end
        checks++; if (ur_cnt != 0) begin errors++; $display("FAIL b2b_underrun_count got %0d want 0", ur_cnt); end
    endtask

    task automatic test_wrap_push();
        run(4095, 1'b0);
        in_valid = 1'b1; in_data = 16'h8000;
        step();
        in_valid = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL wrap_push_underrun got %b want 1", underrun); end
        checks++; if (duty !== 12'd2816) begin errors++; $display("FAIL wrap_push_duty_held got %0d want 2816", duty); end
        hi_cnt = 0; ur_cnt = 0;
        run(4096, 1'b0);
        checks++; if (hi_cnt != 2816) begin errors++; $display("FAIL wrap_push_high got %0d want 2816", hi_cnt); end
        checks++; if (ur_cnt != 0) begin errors++; $display("FAIL wrap_push_underrun_next got %0d want 0", ur_cnt); end
        checks++; if (duty !== 12'd0) begin errors++; $display("FAIL wrap_push_loaded got %0d want 0", duty); end
    endtask

    task automatic test_clk_en_half();
        hi_cnt = 0; ur_cnt = 0;
        clk_en = 1'b1; in_valid = 1'b1; in_data = 16'hC000;
        step();
        clk_en = 1'b0;
        step();
        in_valid = 1'b0; clk_en = 1'b1;
        run(4095, 1'b1);
        checks++; if (hi_cnt != 0) begin errors++; $display("FAIL half_high_p0 got %0d want 0", hi_cnt); end
        checks++; if (ur_cnt != 0) begin errors++; $display("FAIL half_underrun_p0 got %0d want 0", ur_cnt); end
        checks++; if (duty !== 12'd1024) begin errors++; $display("FAIL half_duty got %0d want 1024", duty); end
        hi_cnt = 0; ur_cnt = 0;
        run(4096, 1'b1);
        checks++; if (hi_cnt != 2048) begin errors++; $display("FAIL half_high_p1 got %0d want 2048", hi_cnt); end
        checks++; if (ur_cnt != 1) begin errors++; $display("FAIL half_underrun_p1 got %0d want 1", ur_cnt); end
        checks++; if (duty !== 12'd1024) begin errors++; $display("FAIL half_duty_held got %0d want 1024", duty); end
    endtask

    task automatic test_mid_reset();
        clk_en = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
        step();
        in_valid = 1'b0;
        run(999, 1'b0);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h7FFF;
        step();
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++; if (duty !== 12'd2048) begin errors++; $display("FAIL midrst_duty got %0d want 2048", duty); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL midrst_pwm got %b want 0", pwm_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got %b want 0", underrun); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        hi_cnt = 0; ur_cnt = 0;
        run(4096, 1'b0);
        checks++; if (hi_cnt != 2048) begin errors++; $display("FAIL midrst_high got %0d want 2048", hi_cnt); end
        checks++; if (ur_cnt != 1) begin errors++; $display("FAIL midrst_underrun_count got %0d want 1", ur_cnt); end
        checks++; if (duty !== 12'd2048) begin errors++; $display("FAIL midrst_duty_after got %0d want 2048", duty); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_duty_sequence();
        test_back_to_back();
        test_wrap_push();
        test_clk_en_half();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/q15_pwm_dac.md
Q15_PWM_DAC -- requirements
Module: q15_pwm_dac

Interface
REQ-001 SHALL have parameter PWM_BITS, default 12: PWM resolution; the period is 2^PWM_BITS clk_en ticks.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of sample-buffer entries, a power of two of at least 2.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port clk_en, input, 1: tick enable; all state advances only when clk_en=1.
REQ-006 SHALL have port in_valid, input, 1: filtered sample present.
REQ-007 SHALL have port in_data, input, 16: signed Q1.15 sample from the noise filter.
REQ-008 SHALL have port in_ready, output, 1: buffer can accept a sample.
REQ-009 SHALL have port pwm_out, output, 1: registered PWM drive to the external RC DAC.
REQ-010 SHALL have port duty, output, PWM_BITS: active duty code, offset binary.
REQ-011 SHALL have port underrun, output, 1: one-tick pulse when a period starts with an empty buffer.

Function
REQ-012 SHALL accept a sample when clk_en && in_valid && in_ready.
- in_ready = !full, taken from registered FIFO state.
REQ-013 SHALL store each accepted sample in a FIFO_DEPTH-entry FIFO as its converted code.
- Conversion (default): code = in_data[15:16-PWM_BITS] with the MSB inverted.
- Mapping: -1.0 -> 0, 0.0 -> 2^(PWM_BITS-1), max positive -> 2^PWM_BITS-1.
REQ-014 SHALL keep a PWM_BITS-wide counter cnt that increments by 1 on each clk_en tick and wraps from 2^PWM_BITS-1 to 0.
REQ-015 SHALL act at the wrap tick (cnt = 2^PWM_BITS-1 and clk_en):
- FIFO non-empty: pop the head into duty.
- FIFO empty: hold duty and assert underrun for that tick.
REQ-016 SHALL, on each clk_en tick, set pwm_out <= (cnt < duty), using the pre-update values of cnt and duty.
- A newly loaded duty therefore first drives pwm_out on the tick where cnt = 0.
REQ-017 SHALL give duty = 0 a constant-low output, and duty = 2^PWM_BITS-1 high for 2^PWM_BITS-1 of every 2^PWM_BITS ticks.
REQ-018 SHALL handle a push and a pop on the same wrap tick as follows:
- Both happen; occupancy is unchanged.
- Empty FIFO: the pop sees empty, so underrun pulses and the pushed sample is stored.
- Full FIFO: in_ready=0, so no push occurs even though a pop frees a slot that tick.
REQ-019 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and track full/empty with one extra pointer bit.
REQ-020 SHALL leave all state (cnt, FIFO, duty, pwm_out, underrun) unchanged when clk_en=0, with underrun forced to 0 on those cycles.

Reset
REQ-021 SHALL, while rst_n=0 at a clk edge, set:
- cnt=0, duty=2^(PWM_BITS-1) (midscale, zero signal), pwm_out=0, underrun=0.
- FIFO empty, so in_ready=1 on the first cycle after reset.
REQ-022 SHALL let reset mid-period discard buffered samples and the partial period.
- The next period starts from cnt=0 with midscale duty.
REQ-023 SHALL give reset priority over clk_en and in_valid.

Configuration
REQ-024 SHALL compile in round-to-nearest conversion when macro Q15_PWM_DAC_ROUND_EN is defined:
- Add 2^(15-PWM_BITS) to in_data in 17-bit signed arithmetic.
- Saturate to +32767, then slice as in REQ-013.
REQ-025 SHALL use plain truncation (REQ-013) when Q15_PWM_DAC_ROUND_EN is undefined, with no rounding logic present.

Verification (PWM_BITS=12, FIFO_DEPTH=4, clk_en=1 unless stated)
REQ-026 Reset -> duty=2048, pwm_out low, in_ready=1.
- Then with no input: pwm_out high for exactly 2048 of each 4096 ticks, and underrun pulses once per period.
REQ-027 Push 16'h8000, 16'h7FFF, 16'h0000 -> duty becomes 0, 4095, 2048 on successive periods.
- pwm_out high counts per period: 0, 4095, 2048.
REQ-028 Push 5 samples back-to-back -> in_ready drops after the 4th and the 5th is not accepted.
- in_ready rises the cycle after the next wrap-tick pop.
REQ-029 Push with FIFO empty exactly on the wrap tick -> underrun pulses that tick; the sample loads at the following wrap.
REQ-030 Toggle clk_en at 50% -> period doubles in clk cycles with identical pwm_out tick counts; assert rst_n=0 mid-period -> state matches REQ-021.
REQ-031 In_data 16'h0008, with and without Q15_PWM_DAC_ROUND_EN -> code 2049 and 2048 respectively.
- In_data 16'h7FFF -> 4095 in both builds.
